// File: rtl/cv32e40s_rvfi_obi_instr_tracker.sv
// In-order tracker pairing instruction OBI grants (or PMP-blocked fetches)
// with their responses and handing completed entries to RVFI capture.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   obi_req_i/obi_gnt_i   - address phase handshake, req_payload_i captured on grant
//   obi_rvalid_i          - response phase, resp_payload_i paired in issue order
//   pmp_blk_i             - fetch blocked by PMP, tracked without a bus transaction
//   kill_i                - IF flush; tracked entries dropped, late responses discarded
//   out_valid_o/out_ready_i/out_o - completed head entry handshake
//   full_o                - DEPTH entries tracked
//   outstanding_o         - bus responses still expected (including discarded)
// Optional: define CV32E40S_RVFI_OBI_TRACKER_STATS_EN to add stat_killed_o and
// stat_pmp_o event counters.

package cv32e40s_rvfi_obi_tracker_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [1:0]  memtype;
        logic        dbg;
    } obi_inst_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } inst_resp_t;

    typedef struct packed {
        obi_inst_req_t req;
        inst_resp_t    resp;
        logic          pmp_err;
    } rvfi_obi_instr_t;

endpackage

module cv32e40s_rvfi_obi_instr_tracker
    import cv32e40s_rvfi_obi_tracker_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            obi_req_i,
    input  logic            obi_gnt_i,
    input  obi_inst_req_t   req_payload_i,
    input  logic            obi_rvalid_i,
    input  inst_resp_t      resp_payload_i,
    input  logic            pmp_blk_i,
    input  logic            kill_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output rvfi_obi_instr_t out_o,
    output logic            full_o,
    output logic [CNT_W-1:0] outstanding_o
`ifdef CV32E40S_RVFI_OBI_TRACKER_STATS_EN
    ,
    output logic [31:0]     stat_killed_o,
    output logic [31:0]     stat_pmp_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] pmp_q;
    obi_inst_req_t    req_q  [DEPTH];
    inst_resp_t       resp_q [DEPTH];

    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rsp_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] discard_q;

    logic             push_bus;
    logic             push_pmp;
    logic             push;
    logic             pop;
    logic             rsp_discard;
    logic             rsp_take;
    logic             rsp_dec;
    logic             rsp_hit;
    logic [PTR_W-1:0] rsp_idx;
    logic [CNT_W-1:0] pend_cnt;
    logic [CNT_W:0]   out_sum;
    logic [CNT_W:0]   kill_sum;
    logic [CNT_W-1:0] kill_disc;

    assign push_bus = obi_req_i & obi_gnt_i;
    assign push_pmp = pmp_blk_i;
    assign push     = push_bus | push_pmp;

    // Bus entries still waiting for their response.
    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt = pend_cnt + CNT_W'(valid_q[i] & ~done_q[i]);
        end
    end

    // Oldest pending bus entry at or after rsp; done (PMP) entries are
    // skipped here so a PMP entry ahead of a bus entry never stalls it.
    always_comb begin
        rsp_hit = 1'b0;
        rsp_idx = rsp_q;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[rsp_q + PTR_W'(i)] && !done_q[rsp_q + PTR_W'(i)]) begin
                rsp_hit = 1'b1;
                rsp_idx = rsp_q + PTR_W'(i);
            end
        end
    end

    assign rsp_discard = obi_rvalid_i & (discard_q != '0);
    assign rsp_take    = obi_rvalid_i & (discard_q == '0) & rsp_hit;
    assign rsp_dec     = obi_rvalid_i & ((discard_q != '0) | (pend_cnt != '0));

    assign out_valid_o = valid_q[rd_q] & done_q[rd_q] & ~kill_i;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        out_o         = '0;
        out_o.req     = req_q[rd_q];
        out_o.resp    = resp_q[rd_q];
        out_o.pmp_err = pmp_q[rd_q];
    end

    assign full_o = (occ_q == CNT_W'(DEPTH));

    always_comb begin
        out_sum = {1'b0, pend_cnt} + {1'b0, discard_q};
        if (out_sum > (CNT_W + 1)'(DEPTH)) begin
            outstanding_o = CNT_W'(DEPTH);
        end else begin
            outstanding_o = out_sum[CNT_W-1:0];
        end
    end

    // Responses still owed after a flush: pending bus entries, earlier
    // discards, a grant landing in the flush cycle, minus one consumed now.
    always_comb begin
        kill_sum = {1'b0, pend_cnt} + {1'b0, discard_q}
                 + (CNT_W + 1)'(push_bus) - (CNT_W + 1)'(rsp_dec);
        if (kill_sum > (CNT_W + 1)'(DEPTH)) begin
            kill_disc = CNT_W'(DEPTH);
        end else begin
            kill_disc = kill_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            done_q    <= '0;
            pmp_q     <= '0;
            wr_q      <= '0;
            rsp_q     <= '0;
            rd_q      <= '0;
            occ_q     <= '0;
            discard_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                req_q[i]  <= '0;
                resp_q[i] <= '0;
            end
        end else if (kill_i) begin
            valid_q   <= '0;
            done_q    <= '0;
            pmp_q     <= '0;
            wr_q      <= '0;
            rsp_q     <= '0;
            rd_q      <= '0;
            occ_q     <= '0;
            discard_q <= kill_disc;
        end else begin
            if (pop) begin
                valid_q[rd_q] <= 1'b0;
                done_q[rd_q]  <= 1'b0;
                rd_q          <= rd_q + PTR_W'(1);
            end
            if (push) begin
                valid_q[wr_q] <= 1'b1;
                done_q[wr_q]  <= push_pmp;
                pmp_q[wr_q]   <= push_pmp;
                req_q[wr_q]   <= req_payload_i;
                resp_q[wr_q]  <= '0;
                wr_q          <= wr_q + PTR_W'(1);
            end
            if (rsp_take) begin
                resp_q[rsp_idx] <= resp_payload_i;
                done_q[rsp_idx] <= 1'b1;
                rsp_q           <= rsp_idx + PTR_W'(1);
            end
            if (rsp_discard) begin
                discard_q <= discard_q - CNT_W'(1);
            end
            occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef CV32E40S_RVFI_OBI_TRACKER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_killed_o <= '0;
            stat_pmp_o    <= '0;
        end else begin
            if (rsp_discard) begin
                stat_killed_o <= stat_killed_o + 32'd1;
            end
            if (push_pmp && !kill_i) begin
                stat_pmp_o <= stat_pmp_o + 32'd1;
            end
        end
    end
`else
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push_bus && push_pmp));
            assert (!(push && full_o));
            assert (!(obi_rvalid_i && discard_q == '0 && pend_cnt == '0));
        end
    end
`endif

endmodule

// File: tb/tb_cv32e40s_rvfi_obi_instr_tracker.sv
// Directed bench for the instruction OBI tracker.
// Walks the fetch, ordering, PMP, flush, backpressure and reset scenarios.

module tb_cv32e40s_rvfi_obi_instr_tracker;
    import cv32e40s_rvfi_obi_tracker_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            obi_req_i;
    logic            obi_gnt_i;
    obi_inst_req_t   req_payload_i;
    logic            obi_rvalid_i;
    inst_resp_t      resp_payload_i;
    logic            pmp_blk_i;
    logic            kill_i;
    logic            out_valid_o;
    logic            out_ready_i;
    rvfi_obi_instr_t out_o;
    logic            full_o;
    logic [1:0]      outstanding_o;

    int n_cmp = 0;
    int n_bad = 0;

    cv32e40s_rvfi_obi_instr_tracker #(.DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .obi_req_i      (obi_req_i),
        .obi_gnt_i      (obi_gnt_i),
        .req_payload_i  (req_payload_i),
        .obi_rvalid_i   (obi_rvalid_i),
        .resp_payload_i (resp_payload_i),
        .pmp_blk_i      (pmp_blk_i),
        .kill_i         (kill_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_o          (out_o),
        .full_o         (full_o),
        .outstanding_o  (outstanding_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        obi_req_i      = 1'b0;
        obi_gnt_i      = 1'b0;
        obi_rvalid_i   = 1'b0;
        pmp_blk_i      = 1'b0;
        kill_i         = 1'b0;
        req_payload_i  = '0;
        resp_payload_i = '0;
    endtask

    task automatic grant(input logic [31:0] a);
        obi_req_i          = 1'b1;
        obi_gnt_i          = 1'b1;
        req_payload_i      = '0;
        req_payload_i.addr = a;
    endtask

    task automatic rsp(input logic [31:0] d);
        obi_rvalid_i         = 1'b1;
        resp_payload_i       = '0;
        resp_payload_i.rdata = d;
    endtask

    task automatic head(input string tag, input logic [31:0] a,
                        input logic [31:0] d, input logic p);
        chk({tag, "_valid"}, 72'(out_valid_o), 72'(1));
        chk({tag, "_addr"}, 72'(out_o.req.addr), 72'(a));
        chk({tag, "_rdata"}, 72'(out_o.resp.rdata), 72'(d));
        chk({tag, "_pmp"}, 72'(out_o.pmp_err), 72'(p));
    endtask

    initial begin
        rst_n       = 1'b0;
        out_ready_i = 1'b1;
        idle();
        #3;
        chk("rst_valid", 72'(out_valid_o), 72'(0));
        chk("rst_full", 72'(full_o), 72'(0));
        chk("rst_outst", 72'(outstanding_o), 72'(0));
        chk("rst_out", 72'(out_o), 72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // single fetch
        grant(32'h80);
        #1 chk("t1_outst0", 72'(outstanding_o), 72'(0));
        cyc();
        idle();
        #1 chk("t1_outst1", 72'(outstanding_o), 72'(1));
        chk("t1_nv0", 72'(out_valid_o), 72'(0));
        cyc();
        rsp(32'h13);
        #1 chk("t1_nv1", 72'(out_valid_o), 72'(0));
        cyc();
        idle();
        #1 head("t1", 32'h80, 32'h13, 1'b0);
        chk("t1_outst2", 72'(outstanding_o), 72'(0));
        cyc();
        #1 chk("t1_empty", 72'(out_valid_o), 72'(0));
        chk("t1_full", 72'(full_o), 72'(0));

        // back-to-back
        grant(32'h100);
        cyc();
        grant(32'h104);
        #1 chk("t2_full0", 72'(full_o), 72'(0));
        cyc();
        idle();
        #1 chk("t2_full1", 72'(full_o), 72'(1));
        chk("t2_outst", 72'(outstanding_o), 72'(2));
        cyc();
        rsp(32'hA);
        #1 chk("t2_nv", 72'(out_valid_o), 72'(0));
        cyc();
        rsp(32'hB);
        #1 head("t2a", 32'h100, 32'hA, 1'b0);
        chk("t2_outst1", 72'(outstanding_o), 72'(1));
        cyc();
        idle();
        #1 head("t2b", 32'h104, 32'hB, 1'b0);
        chk("t2_full2", 72'(full_o), 72'(0));
        cyc();
        #1 chk("t2_empty", 72'(out_valid_o), 72'(0));

        // PMP mix
        grant(32'h200);
        cyc();
        idle();
        pmp_blk_i          = 1'b1;
        req_payload_i.addr = 32'h204;
        #1 chk("t3_nv0", 72'(out_valid_o), 72'(0));
        cyc();
        idle();
        rsp(32'h55);
        #1 chk("t3_nv1", 72'(out_valid_o), 72'(0));
        chk("t3_full", 72'(full_o), 72'(1));
        cyc();
        idle();
        #1 head("t3a", 32'h200, 32'h55, 1'b0);
        cyc();
        #1 head("t3b", 32'h204, 32'h0, 1'b1);
        cyc();
        #1 chk("t3_empty", 72'(out_valid_o), 72'(0));

        // kill with two outstanding
        grant(32'h300);
        cyc();
        grant(32'h304);
        cyc();
        idle();
        kill_i = 1'b1;
        #1 chk("t4_kv", 72'(out_valid_o), 72'(0));
        chk("t4_kout", 72'(outstanding_o), 72'(2));
        cyc();
        idle();
        #1 chk("t4_outst2", 72'(outstanding_o), 72'(2));
        chk("t4_full", 72'(full_o), 72'(0));
        rsp(32'hDEAD);
        cyc();
        #1 chk("t4_outst1", 72'(outstanding_o), 72'(1));
        chk("t4_nv1", 72'(out_valid_o), 72'(0));
        cyc();
        idle();
        #1 chk("t4_outst0", 72'(outstanding_o), 72'(0));
        chk("t4_nv2", 72'(out_valid_o), 72'(0));
        grant(32'h400);
        cyc();
        idle();
        rsp(32'h77);
        #1 chk("t4_new_outst", 72'(outstanding_o), 72'(1));
        cyc();
        idle();
        #1 head("t4n", 32'h400, 32'h77, 1'b0);
        cyc();
        #1 chk("t4_empty", 72'(out_valid_o), 72'(0));

        // kill coincident with rvalid and grant
        grant(32'h500);
        cyc();
        grant(32'h504);
        rsp(32'h99);
        kill_i = 1'b1;
        #1 chk("t5_kv", 72'(out_valid_o), 72'(0));
        cyc();
        idle();
        #1 chk("t5_disc", 72'(outstanding_o), 72'(1));
        chk("t5_nv0", 72'(out_valid_o), 72'(0));
        chk("t5_full", 72'(full_o), 72'(0));
        rsp(32'h98);
        cyc();
        idle();
        #1 chk("t5_outst0", 72'(outstanding_o), 72'(0));
        chk("t5_nv1", 72'(out_valid_o), 72'(0));
        cyc();
        #1 chk("t5_nv2", 72'(out_valid_o), 72'(0));

        // backpressure
        out_ready_i = 1'b0;
        grant(32'h600);
        cyc();
        grant(32'h604);
        cyc();
        idle();
        rsp(32'h61);
        cyc();
        rsp(32'h62);
        #1 head("t6a", 32'h600, 32'h61, 1'b0);
        chk("t6_full0", 72'(full_o), 72'(1));
        cyc();
        idle();
        #1 head("t6b", 32'h600, 32'h61, 1'b0);
        chk("t6_full1", 72'(full_o), 72'(1));
        cyc();
        #1 head("t6c", 32'h600, 32'h61, 1'b0);
        out_ready_i = 1'b1;
        cyc();
        #1 head("t6d", 32'h604, 32'h62, 1'b0);
        chk("t6_full2", 72'(full_o), 72'(0));
        cyc();
        #1 chk("t6_empty", 72'(out_valid_o), 72'(0));
        chk("t6_outst", 72'(outstanding_o), 72'(0));

        // asynchronous reset mid-operation
        grant(32'h700);
        cyc();
        idle();
        #1 chk("t7_pre", 72'(outstanding_o), 72'(1));
        rst_n = 1'b0;
        #1 chk("t7_outst", 72'(outstanding_o), 72'(0));
        chk("t7_full", 72'(full_o), 72'(0));
        chk("t7_out", 72'(out_o), 72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        #1 chk("t7_nv", 72'(out_valid_o), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
